gf180mcu_sram_banked: RTL and testbench

//  Depth- and width-scalable single-port SRAM built from gf180mcu_fd_ip_sram__sramNx8m8wm1 macros:

---
 rtl/gf180mcu_sram_banked_if.sv | 21 ++
 rtl/gf180mcu_sram_banked.sv | 122 ++++++++++++
 tb/tb_gf180mcu_sram_banked.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_sram_banked_if.sv
// gf180mcu_sram_banked_if: valid/ready request and buffered response bus of the banked SRAM
interface gf180mcu_sram_banked_if #(
    parameter int WORDS = 2048,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WORDS);
    logic req_valid, req_ready, req_we;
    logic [WIDTH/8-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic rsp_valid, rsp_ready, rsp_err;
    logic [WIDTH-1:0] rsp_rdata;
    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/gf180mcu_sram_banked.sv
// gf180mcu_sram_banked: ROWS x (WIDTH/8) array of Nx8 SRAM macros with row decode,
// optional zero-fill after reset and a credit-controlled 2-entry read response FIFO.
module gf180mcu_sram_banked #(
    parameter int WORDS = 2048,
    parameter int WIDTH = 32,
    parameter int MACRO_WORDS = 512,
    parameter int INIT_ZERO = 1
) (
    input logic clk,
    input logic rst,
    output logic init_done_o,
    gf180mcu_sram_banked_if.slave bus
);
    localparam int NB = WIDTH / 8;
    localparam int ROWS = WORDS / MACRO_WORDS;
    localparam int MB = $clog2(MACRO_WORDS);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

    if (MACRO_WORDS != 64 && MACRO_WORDS != 128 && MACRO_WORDS != 256 && MACRO_WORDS != 512) begin : g_bad_macro
        $error("MACRO_WORDS must be 64, 128, 256 or 512");
    end
    if (WORDS % MACRO_WORDS != 0 || WIDTH % 8 != 0) begin : g_bad_geom
        $error("WORDS must be a multiple of MACRO_WORDS and WIDTH a multiple of 8");
    end

    typedef enum logic {INIT, RUN} state_e;
    state_e state_q, state_d;
    logic [MB-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row, row_q;
    logic in_range, acc, rd_ok, pop, rd_q, err_q;
    logic [2:0] occ;
    logic [1:0] fc_q;
    logic wp_q, rp_q;
    logic [1:0][WIDTH:0] f_q;
    logic [ROWS-1:0] cen;
    logic gwen;
    logic [WIDTH-1:0] wen, d, rd_data;
    logic [MB-1:0] a;
    logic [ROWS-1:0][WIDTH-1:0] q;

    assign in_range = 32'(bus.req_addr) < 32'(WORDS);
    assign row = RW'(bus.req_addr >> MB);
    assign pop = bus.rsp_valid && bus.rsp_ready;
    // Occupancy the FIFO will reach once the in-flight read lands, net of this cycle's pop
    assign occ = 3'(fc_q) + 3'(rd_q) - 3'(pop);
    assign rd_ok = occ < 3'd2;
    assign bus.req_ready = state_q == RUN && (bus.req_we || rd_ok);
    assign acc = bus.req_valid && bus.req_ready;
    assign init_done_o = state_q == RUN;
    assign bus.rsp_valid = fc_q != 2'd0;
    assign {bus.rsp_err, bus.rsp_rdata} = f_q[rp_q];
    assign rd_data = err_q ? '0 : q[row_q];

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            state_d = (INIT_ZERO == 0 || &cnt_q) ? RUN : INIT;
        end
    end

    always_comb begin
        cen = '1;
        gwen = 1'b1;
        wen = '1;
        a = bus.req_addr[MB-1:0];
        d = bus.req_wdata;
        if (state_q == INIT && INIT_ZERO != 0) begin
            cen = '0;
            gwen = 1'b0;
            wen = '0;
            a = cnt_q;
            d = '0;
        end else if (acc && in_range && !(bus.req_we && bus.req_be == '0)) begin
            cen[row] = 1'b0;
            gwen = ~bus.req_we;
            for (int k = 0; k < NB; k++) wen[8*k+:8] = {8{~(bus.req_we && bus.req_be[k])}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q <= '0;
            rd_q <= 1'b0;
            err_q <= 1'b0;
            row_q <= '0;
            fc_q <= '0;
            wp_q <= 1'b0;
            rp_q <= 1'b0;
            f_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rd_q <= acc && !bus.req_we;
            err_q <= !in_range;
            row_q <= row;
            fc_q <= fc_q + 2'(rd_q) - 2'(pop);
            if (rd_q) begin
                f_q[wp_q] <= {err_q, rd_data};
                wp_q <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(rd_q && !pop && fc_q == 2'd2));

    // Behavioural stand-in for each Nx8 macro: active-low CEN/GWEN/WEN, Q updates on reads only
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            logic [7:0] mem [MACRO_WORDS];
            logic [7:0] q_q;
            always_ff @(posedge clk) begin
                if (!cen[r] && !gwen) mem[a] <= (mem[a] & wen[8*c+:8]) | (d[8*c+:8] & ~wen[8*c+:8]);
                if (!cen[r] && gwen) q_q <= mem[a];
            end
            assign q[r][8*c+:8] = q_q;
        end
    end
endmodule

// File: tb/tb_gf180mcu_sram_banked.sv
// tb_gf180mcu_sram_banked: table-driven vectors plus hand sequences, responses checked
// through an expectation queue filled at request acceptance.
module tb_gf180mcu_sram_banked;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic done_a, done_b;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf180mcu_sram_banked_if #(.WORDS(2048), .WIDTH(32)) ba ();
    gf180mcu_sram_banked_if #(.WORDS(1536), .WIDTH(32)) bb ();

    gf180mcu_sram_banked #(.WORDS(2048), .WIDTH(32), .MACRO_WORDS(512), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst), .init_done_o(done_a), .bus(ba)
    );
    gf180mcu_sram_banked #(.WORDS(1536), .WIDTH(32), .MACRO_WORDS(512), .INIT_ZERO(0)) dut_b (
        .clk(clk), .rst(rst), .init_done_o(done_b), .bus(bb)
    );

    typedef struct {
        bit we;
        logic [3:0] be;
        logic [10:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [3:0] cen;
    } vec_t;
    typedef struct {
        logic err;
        logic [31:0] data;
        int acc_cyc;
        bit lat;
    } exp_t;

    vec_t v[17];
    int rd_idx[8];
    exp_t q_exp[$];
    int rsp_cyc[$];
    logic cur_err;
    logic [31:0] cur_data;
    bit cur_lat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ba.req_valid && ba.req_ready && !ba.req_we) q_exp.push_back('{cur_err, cur_data, cyc, cur_lat});
            if (ba.rsp_valid && ba.rsp_ready) begin
                rsp_cyc.push_back(cyc);
                if (q_exp.size() == 0) chk("rsp_unexpected", 64'(ba.rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = q_exp.pop_front();
                    chk("rsp_data", {31'd0, ba.rsp_err, ba.rsp_rdata}, {31'd0, e.err, e.data});
                    if (e.lat) chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
        end
    end

    task automatic req(input vec_t t, input bit lat, output logic [3:0] cen_s);
        bit ok = 1'b0;
        ba.req_valid = 1'b1;
        ba.req_we = t.we;
        ba.req_be = t.be;
        ba.req_addr = t.addr;
        ba.req_wdata = t.wd;
        cur_err = 1'b0;
        cur_data = t.exp;
        cur_lat = lat;
        cen_s = 4'hx;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = ba.req_ready;
            cen_s = dut.cen;
            @(posedge clk);
            #1;
        end
        ba.req_valid = 1'b0;
        chk("req_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && q_exp.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain", 64'(q_exp.size()), 64'd0);
    endtask

    task automatic wait_init(input string nm, output int fb);
        int c0 = cyc;
        fb = -1;
        for (int n = 0; n < 2000 && !done_a; n++) begin
            @(negedge clk);
            if (done_b && fb < 0) fb = cyc - c0;
        end
        chk(nm, 64'(cyc - c0), 64'd512);
    endtask

    task automatic b_op(input logic we, input logic [10:0] addr, input logic [31:0] wd, output logic [2:0] cen_s);
        bb.req_valid = 1'b1;
        bb.req_we = we;
        bb.req_be = 4'hF;
        bb.req_addr = addr;
        bb.req_wdata = wd;
        @(negedge clk);
        chk("b_ready", 64'(bb.req_ready), 64'd1);
        cen_s = dut_b.cen;
        @(posedge clk);
        #1 bb.req_valid = 1'b0;
    endtask

    task automatic b_rsp(input string nm, input logic err, input logic [31:0] dat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bb.rsp_valid && n < 10);
        chk(nm, {30'd0, bb.rsp_valid, bb.rsp_err, bb.rsp_rdata}, {30'd0, 1'b1, err, dat});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cs;
        logic [2:0] cb;
        int fb, n_acc, c0;
        v = '{
            '{1, 4'hF, 11'h5FF, 32'hDEADBEEF, 32'h0,        4'b1011},
            '{1, 4'h5, 11'h5FF, 32'h11223344, 32'h0,        4'b1011},
            '{0, 4'h0, 11'h5FF, 32'h0,        32'hDE22BE44, 4'b1011},
            '{0, 4'h0, 11'h5DC, 32'h0,        32'h0,        4'b1011},
            '{1, 4'hF, 11'h000, 32'hA0A0A0A0, 32'h0,        4'b1110},
            '{1, 4'hF, 11'h200, 32'hB1B1B1B1, 32'h0,        4'b1101},
            '{1, 4'hF, 11'h400, 32'hC2C2C2C2, 32'h0,        4'b1011},
            '{1, 4'hF, 11'h600, 32'hD3D3D3D3, 32'h0,        4'b0111},
            '{1, 4'h0, 11'h000, 32'hFFFFFFFF, 32'h0,        4'b1111},
            '{0, 4'h0, 11'h000, 32'h0,        32'hA0A0A0A0, 4'b1110},
            '{0, 4'h0, 11'h200, 32'h0,        32'hB1B1B1B1, 4'b1101},
            '{0, 4'h0, 11'h400, 32'h0,        32'hC2C2C2C2, 4'b1011},
            '{0, 4'h0, 11'h600, 32'h0,        32'hD3D3D3D3, 4'b0111},
            '{1, 4'hF, 11'h123, 32'hCAFEF00D, 32'h0,        4'b1110},
            '{0, 4'h0, 11'h123, 32'h0,        32'hCAFEF00D, 4'b1110},
            '{1, 4'hA, 11'h7FF, 32'h12345678, 32'h0,        4'b0111},
            '{0, 4'h0, 11'h7FF, 32'h0,        32'h12005600, 4'b0111}
        };
        rd_idx = '{2, 3, 9, 10, 11, 12, 14, 16};
        ba.req_valid = 1'b0; ba.req_we = 1'b0; ba.req_be = '0; ba.req_addr = '0; ba.req_wdata = '0; ba.rsp_ready = 1'b1;
        bb.req_valid = 1'b0; bb.req_we = 1'b0; bb.req_be = '0; bb.req_addr = '0; bb.req_wdata = '0; bb.rsp_ready = 1'b1;

        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", {59'd0, done_a, ba.req_ready, ba.rsp_valid, ba.rsp_err, |ba.rsp_rdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_init("init_done_512", fb);
        chk("init_done_noinit", 64'(fb), 64'd1);

        for (int i = 0; i < 17; i++) begin
            req(v[i], !v[i].we, cs);
            chk($sformatf("vec%0d_cen", i), 64'(cs), 64'(v[i].cen));
        end
        drain();

        rsp_cyc.delete();
        foreach (rd_idx[i]) req(v[rd_idx[i]], 1'b1, cs);
        drain();
        chk("stream_count", 64'(rsp_cyc.size()), 64'd8);
        for (int i = 1; i < rsp_cyc.size(); i++) chk("stream_consec", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd1);

        ba.rsp_ready = 1'b0;
        ba.req_valid = 1'b1; ba.req_we = 1'b0; ba.req_addr = 11'h200;
        cur_err = 1'b0; cur_data = 32'hB1B1B1B1; cur_lat = 1'b0;
        n_acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (ba.req_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        chk("bp_reads_accepted", 64'(n_acc), 64'd2);
        @(negedge clk);
        chk("bp_read_ready", 64'(ba.req_ready), 64'd0);
        chk("bp_hold", {31'd0, ba.rsp_valid, ba.rsp_rdata}, {31'd0, 1'b1, 32'hB1B1B1B1});
        ba.req_we = 1'b1; ba.req_be = 4'hF; ba.req_addr = 11'h050; ba.req_wdata = 32'h55AA55AA;
        #1 chk("bp_write_ready", 64'(ba.req_ready), 64'd1);
        @(posedge clk);
        #1 ba.req_valid = 1'b0; ba.req_we = 1'b0;
        #2 rst = 1'b1;
        #1 chk("reset_queued", {59'd0, done_a, ba.req_ready, ba.rsp_valid, ba.rsp_err, |ba.rsp_rdata}, 64'd0);
        q_exp.delete();
        ba.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        c0 = cyc;
        ba.req_we = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("init_ready_low", {62'd0, done_a, ba.req_ready}, 64'd0);
        chk("mid_init_cycle", 64'(cyc - c0), 64'd100);
        ba.req_we = 1'b0;
        rst = 1'b1;
        #1 chk("reset_mid_init", {61'd0, done_a, ba.req_ready, ba.rsp_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_init("reinit_done_512", fb);
        req('{0, 4'h0, 11'h200, 32'h0, 32'h0, 4'b1101}, 1'b1, cs);
        req('{0, 4'h0, 11'h5FF, 32'h0, 32'h0, 4'b1011}, 1'b1, cs);
        drain();

        b_op(1'b1, 11'h5FF, 32'h0BADCAFE, cb);
        chk("b_cen_5ff", 64'(cb), 64'b011);
        b_op(1'b1, 11'h700, 32'hFFFFFFFF, cb);
        chk("b_cen_oor", 64'(cb), 64'b111);
        b_op(1'b0, 11'h700, 32'h0, cb);
        b_rsp("b_rsp_oor", 1'b1, 32'h0);
        b_op(1'b0, 11'h5FF, 32'h0, cb);
        b_rsp("b_rsp_5ff", 1'b0, 32'h0BADCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
